// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared definitions for the arbitrated adder. It holds the FSM
//            state encoding, the default operand width and requester count,
//            and a helper that sizes requester-index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a requester count. A single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant. The search starts one position
//            after i_ptr, the last-granted index, and wraps modulo NREQ. At
//            most one grant bit is set.
// Ports    : i_req   [NREQ-1:0] request vector
//            i_ptr   [IDW-1:0]  last-granted index
//            o_grant [NREQ-1:0] one-hot grant, all zero when no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import adder_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // k = NREQ wraps back to i_ptr itself. The last-granted requester
    // therefore has the lowest priority but is still eligible.
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = IDW'((int'(i_ptr) + k) % int'(NREQ));
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Purpose  : NREQ requesters share one N-bit adder. In IDLE, a round-robin
//            grant accepts one request and latches its operands. EXEC
//            computes a + b + cin and registers the result. DONE holds the
//            result until the consumer accepts it. The block also counts
//            completed operations and overflows, and both counters saturate.
// Ports    : clk, rst_n            clock, async active-low reset
//            req_valid/req_ready   per-requester handshake [NREQ]
//            req_a/req_b           packed operands, requester i at [i*N +: N]
//            req_cin               per-requester carry-in [NREQ]
//            res_valid/res_ready   result handshake
//            res_id                owning requester index
//            res_sum/res_cout/res_of  sum, carry-out, signed overflow
//            ops_cnt/of_cnt        16-bit saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter
  import adder_pkg::*;
#(
  parameter  int unsigned N    = DEF_N,
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [N-1:0]      res_sum,
  output logic              res_cout,
  output logic              res_of,
  output logic [15:0]       ops_cnt,
  output logic [15:0]       of_cnt
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_cin;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gnt_idx;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic            w_sel_cin;
  logic            w_accept;
  logic [N:0]      w_sum_full;
  logic            w_of;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Convert the one-hot grant to an index and mux the granted operands.
  always_comb begin
    w_gnt_idx = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_gnt_idx = IDW'(i);
        w_sel_a   = req_a[i*N +: N];
        w_sel_b   = req_b[i*N +: N];
        w_sel_cin = req_cin[i];
      end
    end
  end

  assign w_accept = (r_state == IDLE) && (|req_valid);

  // Gating req_ready with rst_n keeps every output at zero while reset is
  // held, even if a requester is already asserting valid.
  assign req_ready = ((r_state == IDLE) && rst_n) ? w_grant : '0;

  assign w_sum_full = {1'b0, r_a} + {1'b0, r_b} + {{N{1'b0}}, r_cin};
  // Overflow: both operands have the same sign, and the sum's sign differs.
  assign w_of = (r_a[N-1] == r_b[N-1]) && (w_sum_full[N-1] != r_a[N-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= IDW'(NREQ - 1);
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_of    <= 1'b0;
      ops_cnt   <= '0;
      of_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_cin   <= w_sel_cin;
            r_id    <= w_gnt_idx;
            r_ptr   <= w_gnt_idx;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          res_sum   <= w_sum_full[N-1:0];
          res_cout  <= w_sum_full[N];
          res_of    <= w_of;
          res_id    <= r_id;
          res_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            r_state   <= IDLE;
            if (ops_cnt != 16'hFFFF) begin
              ops_cnt <= ops_cnt + 16'd1;
            end
            if (res_of && (of_cnt != 16'hFFFF)) begin
              of_cnt <= of_cnt + 16'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Purpose  : Self-checking bench for adder_arbiter. A transaction-level
//            model tracks the in-flight operation, the round-robin pointer
//            and the counters. A compare thread checks the DUT against the
//            model on every falling edge. Directed sequences pin the model
//            with literal expectations, and a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [N-1:0]      res_sum;
  logic              res_cout;
  logic              res_of;
  logic [15:0]       ops_cnt;
  logic [15:0]       of_cnt;

  adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_of    (res_of),
    .ops_cnt   (ops_cnt),
    .of_cnt    (of_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic. The carry comes from the full-width unsigned sum.
  // Overflow means the true signed sum is outside the 32-bit signed range.
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output logic [31:0] sum, output logic cout, output logic of);
    longint unsigned u;
    longint          s;
    u    = longint'(a) + longint'(b) + longint'(cin);
    sum  = u[31:0];
    cout = u[32];
    s    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    of   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  // ---------------- behavioural model state ----------------
  bit          m_busy  = 1'b0;
  int          m_acc   = 0;
  int          m_edges = 0;
  int          m_ptr   = NREQ - 1;
  int          m_ops   = 0;
  int          m_ofc   = 0;
  int          m_id    = 0;
  logic [31:0] m_sum   = '0;
  logic        m_cout  = 1'b0;
  logic        m_of    = 1'b0;

  task automatic monitor_loop();
    int          gi;
    int          j;
    logic [3:0]  exp_rdy;
    bit          exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ops_cnt", ops_cnt, 0);
        chk("rst_of_cnt", of_cnt, 0);
        chk("rst_res_sum", res_sum, 0);
        m_busy  = 1'b0;
        m_ptr   = NREQ - 1;
        m_ops   = 0;
        m_ofc   = 0;
        m_edges = 0;
      end else begin
        gi = -1;
        if (!m_busy) begin
          for (int k = 1; k <= NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (gi < 0 && req_valid[j]) gi = j;
          end
        end
        exp_rdy = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
        chk("m_req_ready", req_ready, exp_rdy);
        // The result is visible after one edge past the accepting edge.
        exp_v = m_busy && (m_edges >= m_acc + 1);
        chk("m_res_valid", res_valid, exp_v);
        if (exp_v) begin
          chk("m_res_sum", res_sum, m_sum);
          chk("m_res_cout", res_cout, m_cout);
          chk("m_res_of", res_of, m_of);
          chk("m_res_id", res_id, m_id);
        end
        chk("m_ops_cnt", ops_cnt, m_ops);
        chk("m_of_cnt", of_cnt, m_ofc);
        // Predict the effect of the coming rising edge.
        if (exp_v && res_ready) begin
          m_busy = 1'b0;
          if (m_ops < 16'hFFFF) m_ops++;
          if (m_of && m_ofc < 16'hFFFF) m_ofc++;
        end
        if (gi >= 0) begin
          m_busy = 1'b1;
          m_acc  = m_edges + 1;
          m_ptr  = gi;
          m_id   = gi;
          ref_add(req_a[gi*N +: N], req_b[gi*N +: N], req_cin[gi], m_sum, m_cout, m_of);
        end
        m_edges++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_ops_cnt", ops_cnt, 0);
    chk("reset_of_cnt", of_cnt, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[idx*N +: N] = a;
    req_b[idx*N +: N] = b;
    req_cin[idx]      = cin;
  endtask

  task automatic run_one(input int idx, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] e_sum, input logic e_cout, input logic e_of,
                         input int e_ops, input int e_ofc);
    tick();
    set_op(idx, a, b, cin);
    req_valid = 4'b0001 << idx;
    res_ready = 1'b1;
    @(negedge clk);
    chk("lit_grant", req_ready, 4'b0001 << idx);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("lit_valid_after_1_edge", res_valid, 0);
    @(negedge clk);
    chk("lit_valid_after_2_edges", res_valid, 1);
    chk("lit_sum", res_sum, e_sum);
    chk("lit_cout", res_cout, e_cout);
    chk("lit_of", res_of, e_of);
    chk("lit_id", res_id, idx);
    @(negedge clk);
    chk("lit_valid_cleared", res_valid, 0);
    chk("lit_ops_cnt", ops_cnt, e_ops);
    chk("lit_of_cnt", of_cnt, e_ofc);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int order[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int cnt;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b0;
    fork
      monitor_loop();
    join_none

    do_reset();

    // Directed arithmetic cases on single requesters.
    run_one(0, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1, 1);
    run_one(1, 32'h8000_0001, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 1'b1, 2, 2);
    run_one(2, 32'hFFFF_FFEA, 32'hFFFF_FFEA, 1'b0, 32'hFFFF_FFD4, 1'b1, 1'b0, 3, 2);
    run_one(3, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 4, 2);

    // Round-robin order with all requesters valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    req_valid = '1;
    res_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    for (int c = 0; c < 60 && cnt < 5; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) order[cnt] = j;
        cnt++;
      end
    end
    chk("grant_count", cnt, 5);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("grant_order", order[i], exp_order[i]);
    repeat (3) @(negedge clk);
    chk("ops_cnt_after_5", ops_cnt, 5);

    // Back-pressure in DONE: the result holds and requests are refused.
    tick();
    set_op(2, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    @(negedge clk);
    chk("stall_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    chk("stall_exec_ready", req_ready, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", res_valid, 1);
      chk("stall_sum", res_sum, 32'h2222_2222);
      chk("stall_cout", res_cout, 0);
      chk("stall_of", res_of, 0);
      chk("stall_id", res_id, 2);
      chk("stall_ready", req_ready, 0);
      chk("stall_ops", ops_cnt, 5);
      if (i < 4) @(negedge clk);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall_ops_before_hs", ops_cnt, 5);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("stall_ops_after_hs", ops_cnt, 6);
    chk("stall_valid_cleared", res_valid, 0);

    // Reset during EXEC drops the in-flight operation.
    tick();
    set_op(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rexec_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rexec_valid", res_valid, 0);
    chk("rexec_sum", res_sum, 0);
    chk("rexec_cout", res_cout, 0);
    chk("rexec_of", res_of, 0);
    chk("rexec_id", res_id, 0);
    chk("rexec_ops", ops_cnt, 0);
    chk("rexec_ofc", of_cnt, 0);
    chk("rexec_ready", req_ready, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rexec_next_grant", req_ready, 4'b0001);
    chk("rexec_no_result", res_valid, 0);
    tick();
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rexec_ops_after", ops_cnt, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 9) < 7);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end

    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adder_arbiter
`default_nettype wire
